// File: rtl/msg_write_loader_if.sv
// Byte-stream handshake between the host and msg_write_loader.
// A byte transfers on a rising clock edge when in_valid && in_ready are both high;
// in_last marks the final byte of a message and is meaningful only on a transfer.
interface msg_write_loader_if #(
    parameter int DW = 8
);
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          in_last;

    // Host side drives the byte, loader side answers with ready.
    modport master (output in_valid, output in_data, output in_last, input in_ready);
    modport slave  (input in_valid, input in_data, input in_last, output in_ready);
endinterface

// File: rtl/msg_write_loader.sv
// msg_write_loader: writes an incoming byte stream into the message buffer at
// incrementing addresses, then presents msg_length/start to the reader and holds
// until read_complete, after which it re-arms for the next message.
// Messages longer than MAX_MESSAGE_LENGTH are truncated; the remaining bytes stall
// and begin the next message.
// Optional feature macro: OVERFLOW_FLAG_EN (sticky overflow flag on truncation);
// when undefined, overflow is tied low.
module msg_write_loader #(
    parameter  int MAX_MESSAGE_LENGTH = 55,
    parameter  int DATA_WIDTH         = 8,
    localparam int AW                 = $clog2(MAX_MESSAGE_LENGTH) + 1
) (
    input  logic                  clock,
    input  logic                  reset,
    msg_write_loader_if.slave     in_bus,
    output logic                  mem_we,
    output logic [AW-1:0]         mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [AW-1:0]         msg_length,
    output logic                  start,
    input  logic                  read_complete,
    output logic                  rd_clear,
    output logic                  done,
    output logic                  overflow,
    output logic [1:0]            fsm_state
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] LOAD  = 2'd1;
    localparam logic [1:0] FLUSH = 2'd2;
    localparam logic [1:0] HOLD  = 2'd3;

    localparam logic [AW-1:0] ONE     = AW'(1);
    localparam logic [AW-1:0] MAX_CNT = AW'(MAX_MESSAGE_LENGTH);

    logic [1:0]    state;
    logic [AW-1:0] wr_cnt;
    logic [AW-1:0] wr_addr;
    logic [AW-1:0] next_cnt;
    logic          ready;
    logic          accept;

    // Ready depends on state (and reset) only, never on in_valid.
    assign ready           = !reset && (state == IDLE || state == LOAD);
    assign in_bus.in_ready = ready;
    assign accept          = in_bus.in_valid && ready;
    assign fsm_state       = state;

    // First byte of a message always lands at address 0.
    assign wr_addr  = (state == IDLE) ? '0 : wr_cnt;
    assign next_cnt = wr_addr + ONE;

    // Main FSM plus registered buffer write port and reader handshake.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            wr_cnt     <= '0;
            msg_length <= '0;
            start      <= 1'b0;
            done       <= 1'b0;
            rd_clear   <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            mem_we   <= 1'b0;
            done     <= 1'b0;
            rd_clear <= 1'b0;
            case (state)
                IDLE, LOAD: begin
                    if (accept) begin
                        mem_we     <= 1'b1;
                        mem_addr   <= wr_addr;
                        mem_wdata  <= in_bus.in_data;
                        wr_cnt     <= next_cnt;
                        msg_length <= next_cnt;
                        // Buffer full forces the message closed even without in_last.
                        if (in_bus.in_last || next_cnt == MAX_CNT) begin
                            state <= FLUSH;
                        end else begin
                            state <= LOAD;
                        end
                    end
                end
                FLUSH: begin
                    // Last write has landed; the reader may start now.
                    state <= HOLD;
                    start <= 1'b1;
                end
                HOLD: begin
                    if (read_complete) begin
                        state    <= IDLE;
                        start    <= 1'b0;
                        done     <= 1'b1;
                        rd_clear <= 1'b1;
                        wr_cnt   <= '0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef OVERFLOW_FLAG_EN
    logic overflow_q;
    logic trunc_hit;

    assign trunc_hit = accept && !in_bus.in_last && next_cnt == MAX_CNT;
    assign overflow  = overflow_q;

    // Sticky truncation flag, cleared when the next message begins.
    always_ff @(posedge clock) begin
        if (reset) begin
            overflow_q <= 1'b0;
        end else if (trunc_hit) begin
            overflow_q <= 1'b1;
        end else if (accept && state == IDLE) begin
            overflow_q <= 1'b0;
        end
    end
`else
    assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_msg_write_loader.sv
// Directed testbench for msg_write_loader: streams messages, checks every buffer
// write against an expected queue and checks handshake/status outputs by hand.
module tb_msg_write_loader;
    localparam int MAX = 55;
    localparam int DW  = 8;
    localparam int AW  = $clog2(MAX) + 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;
    localparam logic [1:0] S_HOLD  = 2'd3;

`ifdef OVERFLOW_FLAG_EN
    localparam logic EXP_OVF = 1'b1;
`else
    localparam logic EXP_OVF = 1'b0;
`endif

    // Clock and reset
    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    msg_write_loader_if #(.DW(DW)) in_if ();

    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [AW-1:0] msg_length;
    logic          start;
    logic          read_complete;
    logic          rd_clear;
    logic          done;
    logic          overflow;
    logic [1:0]    fsm_state;

    msg_write_loader #(.MAX_MESSAGE_LENGTH(MAX), .DATA_WIDTH(DW)) dut (
        .clock         (clock),
        .reset         (reset),
        .in_bus        (in_if.slave),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .msg_length    (msg_length),
        .start         (start),
        .read_complete (read_complete),
        .rd_clear      (rd_clear),
        .done          (done),
        .overflow      (overflow),
        .fsm_state     (fsm_state)
    );

    int n_checks = 0;
    int n_pass   = 0;
    logic [AW+DW-1:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Scoreboard: every buffer write must match the oldest expected write.
    always @(negedge clock) begin
        logic [AW+DW-1:0] e;
        if (mem_we === 1'b1) begin
            check("wr_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("wr_addr", mem_addr, e[AW+DW-1:DW]);
                check("wr_data", mem_wdata, e[DW-1:0]);
            end
        end
    end

    // Driver: called at a negedge; presents a byte, waits for ready, returns at the
    // negedge after the transfer edge.
    task automatic send(input logic [DW-1:0] d, input logic l, input logic [AW-1:0] a);
        int waitc = 0;
        in_if.in_valid = 1'b1;
        in_if.in_data  = d;
        in_if.in_last  = l;
        while (in_if.in_ready !== 1'b1 && waitc < 200) begin
            @(negedge clock);
            waitc++;
        end
        check("send_ready", in_if.in_ready, 1);
        if (in_if.in_ready === 1'b1) exp_q.push_back({a, d});
        @(negedge clock);
        in_if.in_valid = 1'b0;
        in_if.in_last  = 1'b0;
    endtask

    // Reader release: called at a negedge in HOLD; returns one cycle later.
    task automatic release_msg();
        check("start_hold", start, 1);
        read_complete = 1'b1;
        @(negedge clock);
        check("done_pulse", done, 1);
        check("rd_clear_pulse", rd_clear, 1);
        check("start_cleared", start, 0);
        check("state_idle", fsm_state, S_IDLE);
        read_complete = 1'b0;
    endtask

    task automatic check_reset_outputs();
        check("rst_in_ready", in_if.in_ready, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_msg_length", msg_length, 0);
        check("rst_start", start, 0);
        check("rst_rd_clear", rd_clear, 0);
        check("rst_done", done, 0);
        check("rst_overflow", overflow, 0);
        check("rst_state", fsm_state, S_IDLE);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        in_if.in_valid = 1'b0;
        in_if.in_data  = '0;
        in_if.in_last  = 1'b0;
        read_complete  = 1'b0;
        reset          = 1'b1;
        repeat (2) @(negedge clock);
        check_reset_outputs();
        reset = 1'b0;
        @(negedge clock);
        check("ready_after_reset", in_if.in_ready, 1);

        // 1: three-byte message, start two cycles after the last accept
        send(8'hA1, 1'b0, 0);
        check("t1_state_load", fsm_state, S_LOAD);
        check("t1_len1", msg_length, 1);
        send(8'hB2, 1'b0, 1);
        send(8'hC3, 1'b1, 2);
        check("t1_state_flush", fsm_state, S_FLUSH);
        check("t1_start_low", start, 0);
        check("t1_ready_flush", in_if.in_ready, 0);
        @(negedge clock);
        check("t1_state_hold", fsm_state, S_HOLD);
        check("t1_start_high", start, 1);
        check("t1_len3", msg_length, 3);
        check("t1_ready_hold", in_if.in_ready, 0);
        release_msg();
        @(negedge clock);
        check("t1_done_low", done, 0);
        check("t1_rd_clear_low", rd_clear, 0);
        check("t1_len_held", msg_length, 3);
        check("t1_start_low2", start, 0);

        // 2: single-byte message
        send(8'h5A, 1'b1, 0);
        @(negedge clock);
        check("t2_start", start, 1);
        check("t2_len1", msg_length, 1);
        release_msg();
        @(negedge clock);

        // 3: exactly MAX bytes, last on the final one; next byte stalls
        for (int i = 0; i < MAX; i++) send(8'(i * 3 + 7), i == MAX - 1, AW'(i));
        check("t3_state_flush", fsm_state, S_FLUSH);
        check("t3_overflow", overflow, 0);
        in_if.in_valid = 1'b1;
        in_if.in_data  = 8'hEE;
        in_if.in_last  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("t3_stall", in_if.in_ready, 0);
        end
        check("t3_len_max", msg_length, MAX);
        check("t3_state_hold", fsm_state, S_HOLD);
        release_msg();
        send(8'hEE, 1'b1, 0);
        @(negedge clock);
        check("t3_next_len", msg_length, 1);
        release_msg();
        @(negedge clock);

        // 4: 60 bytes without last; truncate at MAX, remainder is the next message
        for (int i = 0; i < MAX; i++) send(8'(i + 100), 1'b0, AW'(i));
        check("t4_state_flush", fsm_state, S_FLUSH);
        check("t4_len_max", msg_length, MAX);
        check("t4_overflow_set", overflow, EXP_OVF);
        in_if.in_valid = 1'b1;
        in_if.in_data  = 8'(155);
        in_if.in_last  = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clock);
            check("t4_stall", in_if.in_ready, 0);
        end
        check("t4_state_hold", fsm_state, S_HOLD);
        check("t4_overflow_hold", overflow, EXP_OVF);
        release_msg();
        check("t4_overflow_until_accept", overflow, EXP_OVF);
        send(8'(155), 1'b0, 0);
        check("t4_overflow_cleared", overflow, 0);
        for (int j = 1; j < 5; j++) send(8'(155 + j), j == 4, AW'(j));
        @(negedge clock);
        check("t4_next_len", msg_length, 5);
        check("t4_next_start", start, 1);
        release_msg();
        @(negedge clock);

        // 5: reset in the middle of a message
        for (int i = 0; i < 10; i++) send(8'(i + 8'h40), 1'b0, AW'(i));
        check("t5_len10", msg_length, 10);
        reset = 1'b1;
        @(negedge clock);
        check_reset_outputs();
        reset = 1'b0;
        @(negedge clock);
        check("t5_ready", in_if.in_ready, 1);
        send(8'h11, 1'b0, 0);
        send(8'h22, 1'b0, 1);
        send(8'h33, 1'b1, 2);
        @(negedge clock);
        check("t5_len3", msg_length, 3);
        release_msg();
        @(negedge clock);

        // 6: read_complete outside HOLD is ignored; gaps produce no writes
        read_complete = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clock);
            check("t6_idle_no_done", done, 0);
            check("t6_idle_state", fsm_state, S_IDLE);
        end
        send(8'h61, 1'b0, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("t6_load_no_done", done, 0);
            check("t6_gap_no_we", mem_we, 0);
            check("t6_state_load", fsm_state, S_LOAD);
        end
        send(8'h62, 1'b0, 1);
        check("t6_no_done2", done, 0);
        @(negedge clock);
        check("t6_gap_no_we2", mem_we, 0);
        read_complete = 1'b0;
        send(8'h63, 1'b1, 2);
        @(negedge clock);
        check("t6_state_hold", fsm_state, S_HOLD);
        check("t6_len3", msg_length, 3);
        check("t6_hold_no_done", done, 0);
        release_msg();
        @(negedge clock);

        check("queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
